pwm_ctrl: RTL and testbench

Sequencing controller for the PWM datapath: owns the period counter, the active period/duty registers and the registered PWM output. It accepts new period/duty settings from a host over a valid/ready handshake and double-buffers them, so changes take effect only at a period boundary and never produce a truncated or glitched pulse. It also starts and stops generation cleanly from an enable input.

---
 rtl/pwm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pwm_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ctrl
// Purpose  : PWM sequencing controller. Owns the period counter, the active
//            period/duty registers and the registered PWM output. New
//            period/duty settings arrive over a valid/ready handshake into a
//            shadow register and are applied only at a period boundary (or
//            while idle), so a pulse is never truncated or glitched.
// Ports    : ck          - system clock, all updates on posedge
//            rst_n       - asynchronous active-low reset
//            en          - run request
//            cfg_valid   - host offers a configuration
//            cfg_ready   - shadow register free (transfer on valid && ready)
//            cfg_period  - period in ck cycles, 0 stops generation
//            cfg_duty    - high time in ck cycles
//            pwm_out     - registered PWM output
//            period_end  - registered, high in the last cycle of each period
//            running     - high while in RUN or DRAIN
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             pwm_out,
    output logic             period_end,
    output logic             running
);

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_per_act;
    logic [WIDTH-1:0] r_duty_act;
    logic [WIDTH-1:0] r_per_sh;
    logic [WIDTH-1:0] r_duty_sh;
    logic             r_pending;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_per_nxt;
    logic [WIDTH-1:0] w_duty_nxt;
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_last_nxt;
    logic             w_pending_nxt;
    logic             w_xfer;
    logic             w_wrap;
    logic             w_apply;
    logic             w_active_nxt;

    assign cfg_ready = !r_pending;
    assign running   = (r_state != ST_IDLE);

    // A transfer needs pending=0 and an apply needs pending=1, so the two
    // can never coincide: a transfer on a wrap edge waits for the next wrap.
    assign w_xfer = cfg_valid && !r_pending;

    assign w_last = r_per_act - c_ONE;
    assign w_wrap = (r_cnt == w_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_apply     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = c_ZERO;
                w_apply   = r_pending;
            end
            ST_RUN, ST_DRAIN: begin
                if (w_wrap) begin
                    w_cnt_nxt = c_ZERO;
                    w_apply   = r_pending;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_cnt_nxt = c_ZERO;
            end
        endcase

        // Active values as they stand after any same-edge shadow copy.
        w_per_nxt  = w_apply ? r_per_sh  : r_per_act;
        w_duty_nxt = w_apply ? r_duty_sh : r_duty_act;

        case (r_state)
            ST_IDLE: begin
                if (en && (w_per_nxt != c_ZERO)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wrap && (w_per_nxt == c_ZERO)) begin
                    w_state_nxt = ST_IDLE;
                end else if (!en) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The drain period always finishes; en only rescues it
                // before the wrap edge.
                if (w_wrap) begin
                    w_state_nxt = ST_IDLE;
                end else if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_IDLE) begin
            w_cnt_nxt = c_ZERO;
        end

        w_pending_nxt = w_xfer ? 1'b1 : (w_apply ? 1'b0 : r_pending);
        w_active_nxt  = (w_state_nxt != ST_IDLE);
    end

    assign w_last_nxt = w_per_nxt - c_ONE;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= c_ZERO;
            r_per_act  <= c_ZERO;
            r_duty_act <= c_ZERO;
            r_per_sh   <= c_ZERO;
            r_duty_sh  <= c_ZERO;
            r_pending  <= 1'b0;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_per_act  <= w_per_nxt;
            r_duty_act <= w_duty_nxt;
            r_pending  <= w_pending_nxt;
            if (w_xfer) begin
                r_per_sh  <= cfg_period;
                r_duty_sh <= cfg_duty;
            end
            // Outputs are computed from the next-cycle values so they stay
            // aligned with the registered counter.
            pwm_out    <= w_active_nxt && (w_cnt_nxt < w_duty_nxt);
            period_end <= w_active_nxt && (w_cnt_nxt == w_last_nxt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ctrl
// Purpose  : Directed self-checking bench for pwm_ctrl. Outputs are sampled
//            and inputs driven on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ctrl;

    logic       ck         = 1'b0;
    logic       rst_n      = 1'b0;
    logic       en         = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic [7:0] cfg_period = 8'd0;
    logic [7:0] cfg_duty   = 8'd0;
    logic       cfg_ready;
    logic       pwm_out;
    logic       period_end;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_ctrl #(.WIDTH(8)) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .running    (running)
    );

    always #5 ck = ~ck;

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        cfg_duty   = 8'd0;
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
    endtask

    // Called just after a falling edge; the transfer happens on the next
    // rising edge and the task returns at the falling edge after it.
    task automatic transfer(input logic [7:0] p, input logic [7:0] d);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_duty   = d;
        @(negedge ck);
        cfg_valid = 1'b0;
    endtask

    // After return, the next falling edge observes cycle 0 of the run.
    task automatic start_run(input logic [7:0] p, input logic [7:0] d);
        do_reset();
        transfer(p, d);
        @(negedge ck);
        en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            n_checks++;
            if ({pwm_out, period_end, running, cfg_ready} !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: pwm/pe/run/rdy got %b expected 0001",
                         i, {pwm_out, period_end, running, cfg_ready});
            end
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp;
        int c;
        do_reset();
        transfer(8'd10, 8'd3);
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_low: got %b expected 0", cfg_ready);
        end
        @(negedge ck);
        n_checks++;
        if ({cfg_ready, running} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_idle_applied: rdy/run got %b expected 10", {cfg_ready, running});
        end
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge ck);
            c = i % 10;
            exp[2] = 1'b1;
            exp[1] = (c < 3);
            exp[0] = (c == 9);
            n_checks++;
            if ({running, pwm_out, period_end} !== exp) begin
                n_fail++;
                $display("FAIL basic cycle %0d: run/pwm/pe got %b expected %b",
                         i, {running, pwm_out, period_end}, exp);
            end
        end
    endtask

    task automatic test_mid_update();
        logic [2:0] exp;
        logic       exp_rdy;
        int c;
        start_run(8'd10, 8'd3);
        for (int i = 0; i < 29; i++) begin
            @(negedge ck);
            exp[2] = 1'b1;
            if (i < 10) begin
                exp[1] = (i < 3);
                exp[0] = (i == 9);
            end else begin
                c = (i - 10) % 6;
                exp[1] = (c < 5);
                exp[0] = (c == 5);
            end
            exp_rdy = !(i >= 5 && i <= 9);
            n_checks++;
            if ({running, pwm_out, period_end, cfg_ready} !== {exp, exp_rdy}) begin
                n_fail++;
                $display("FAIL mid_update cycle %0d: run/pwm/pe/rdy got %b expected %b",
                         i, {running, pwm_out, period_end, cfg_ready}, {exp, exp_rdy});
            end
            if (i == 4) begin
                cfg_valid  = 1'b1;
                cfg_period = 8'd6;
                cfg_duty   = 8'd5;
            end else begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_boundary();
        int bp[4] = '{8, 8, 8, 1};
        int bd[4] = '{0, 8, 200, 1};
        logic [2:0] exp;
        int c;
        for (int k = 0; k < 4; k++) begin
            start_run(8'(bp[k]), 8'(bd[k]));
            for (int i = 0; i < 18; i++) begin
                @(negedge ck);
                c = i % bp[k];
                exp[2] = 1'b1;
                exp[1] = (c < bd[k]);
                exp[0] = (c == bp[k] - 1);
                n_checks++;
                if ({running, pwm_out, period_end} !== exp) begin
                    n_fail++;
                    $display("FAIL boundary %0d/%0d cycle %0d: run/pwm/pe got %b expected %b",
                             bp[k], bd[k], i, {running, pwm_out, period_end}, exp);
                end
            end
        end
    endtask

    task automatic test_stop_drain();
        logic [2:0] exp;
        start_run(8'd10, 8'd3);
        for (int i = 0; i < 22; i++) begin
            @(negedge ck);
            if (i <= 9) begin
                exp = {1'b1, 1'(i < 3), 1'(i == 9)};
            end else if (i <= 15) begin
                exp = 3'b000;
            end else begin
                exp = {1'b1, 1'((i - 16) < 3), 1'b0};
            end
            n_checks++;
            if ({running, pwm_out, period_end} !== exp) begin
                n_fail++;
                $display("FAIL stop_drain cycle %0d: run/pwm/pe got %b expected %b",
                         i, {running, pwm_out, period_end}, exp);
            end
            if (i == 2)  en = 1'b0;
            if (i == 15) en = 1'b1;
        end
    endtask

    task automatic test_drain_resume();
        logic [2:0] exp;
        int c;
        start_run(8'd10, 8'd3);
        for (int i = 0; i < 26; i++) begin
            @(negedge ck);
            c = i % 10;
            exp = {1'b1, 1'(c < 3), 1'(c == 9)};
            n_checks++;
            if ({running, pwm_out, period_end} !== exp) begin
                n_fail++;
                $display("FAIL drain_resume cycle %0d: run/pwm/pe got %b expected %b",
                         i, {running, pwm_out, period_end}, exp);
            end
            if (i == 2) en = 1'b0;
            if (i == 5) en = 1'b1;
        end
    endtask

    task automatic test_period_zero();
        logic [3:0] exp;
        start_run(8'd10, 8'd3);
        for (int i = 0; i < 15; i++) begin
            @(negedge ck);
            if (i <= 9) begin
                exp = {1'b1, 1'(i < 3), 1'(i == 9), 1'(i < 4)};
            end else begin
                exp = 4'b0001;
            end
            n_checks++;
            if ({running, pwm_out, period_end, cfg_ready} !== exp) begin
                n_fail++;
                $display("FAIL period_zero cycle %0d: run/pwm/pe/rdy got %b expected %b",
                         i, {running, pwm_out, period_end, cfg_ready}, exp);
            end
            if (i == 3) begin
                cfg_valid  = 1'b1;
                cfg_period = 8'd0;
                cfg_duty   = 8'd0;
            end else begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    // Transfer landing on a wrap edge goes to shadow only.
    task automatic test_wrap_transfer();
        logic [3:0] exp;
        int c;
        start_run(8'd10, 8'd3);
        for (int i = 0; i < 32; i++) begin
            @(negedge ck);
            if (i < 20) begin
                c = i % 10;
                exp = {1'b1, 1'(c < 3), 1'(c == 9), 1'(i < 10)};
            end else begin
                c = (i - 20) % 4;
                exp = {1'b1, 1'(c < 1), 1'(c == 3), 1'b1};
            end
            n_checks++;
            if ({running, pwm_out, period_end, cfg_ready} !== exp) begin
                n_fail++;
                $display("FAIL wrap_transfer cycle %0d: run/pwm/pe/rdy got %b expected %b",
                         i, {running, pwm_out, period_end, cfg_ready}, exp);
            end
            if (i == 9) begin
                cfg_valid  = 1'b1;
                cfg_period = 8'd4;
                cfg_duty   = 8'd1;
            end else begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        start_run(8'd10, 8'd3);
        repeat (2) @(negedge ck);
        n_checks++;
        if ({running, pwm_out} !== 2'b11) begin
            n_fail++;
            $display("FAIL async_pre: run/pwm got %b expected 11", {running, pwm_out});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pwm_out, period_end, running, cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL async_immediate: pwm/pe/run/rdy got %b expected 0001",
                     {pwm_out, period_end, running, cfg_ready});
        end
        @(negedge ck);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ck);
            n_checks++;
            if ({pwm_out, running, cfg_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL async_stay_idle cycle %0d: pwm/run/rdy got %b expected 001",
                         i, {pwm_out, running, cfg_ready});
            end
        end
        transfer(8'd10, 8'd3);
        repeat (3) @(negedge ck);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL async_restart: running got %b expected 1", running);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_update();
        test_boundary();
        test_stop_drain();
        test_drain_resume();
        test_period_zero();
        test_wrap_transfer();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
